// File: rtl/pkg_processador.sv
// Shared definitions for the execute/write-back stage: opcode values,
// instruction field positions, stall FSM states and pipeline payload types.
package pkg_processador;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned OPC_W  = 4;
   localparam int unsigned IMM_W  = 8;

   // Instruction field positions: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 8;
   localparam int unsigned RS_MSB  = 7;
   localparam int unsigned RS_LSB  = 4;
   localparam int unsigned RT_MSB  = 3;
   localparam int unsigned RT_LSB  = 0;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h1;
   localparam logic [OPC_W-1:0] OP_AND = 4'h2;
   localparam logic [OPC_W-1:0] OP_OR  = 4'h3;
   localparam logic [OPC_W-1:0] OP_XOR = 4'h4;
   localparam logic [OPC_W-1:0] OP_SLT = 4'h5;
   localparam logic [OPC_W-1:0] OP_SHL = 4'h6;
   localparam logic [OPC_W-1:0] OP_SHR = 4'h7;
   localparam logic [OPC_W-1:0] OP_MUL = 4'h8;
   localparam logic [OPC_W-1:0] OP_LI  = 4'h9;
   localparam logic [OPC_W-1:0] OP_NOP = 4'hA;   // 0xA..0xF all behave as NOP

   typedef enum logic {
      OCIOSO = 1'b0,
      MULT   = 1'b1
   } estado_t;

   // Accepted instruction waiting for its operands from the bank.
   typedef struct packed {
      logic              valid;
      logic [OPC_W-1:0]  opcode;
      logic [ADDR_W-1:0] rd;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
      logic [IMM_W-1:0]  imm;
   } s1_t;

   // A write-port transaction (also used for the delayed forwarding copy).
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dado;
   } wb_t;

   // Opcodes whose result is produced in a single execute cycle.
   function automatic logic escreve_direto(input logic [OPC_W-1:0] op);
      return (op <= OP_LI) && (op != OP_MUL);
   endfunction

endpackage

// File: rtl/multiplicador_serial.sv
// Iterative 16-step shift-add multiplier returning the low 16 product bits.
// Ports: start (latch a/b, begin), a/b operands, done_c (high during the
// 16th step), produto_c (final product, valid while done_c is high).
module multiplicador_serial
   import pkg_processador::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done_c,
   output logic [DATA_W-1:0] produto_c
);

   logic              ocupado;
   logic [3:0]        passo;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] parcial;

   // Partial product of the current step; the sum is the running product.
   assign parcial   = mplier[0] ? mcand : '0;
   assign produto_c = acc + parcial;
   assign done_c    = ocupado && (passo == 4'd15);

   // One shift-add step per cycle while busy; start overrides any step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ocupado <= 1'b0;
         passo   <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
      end else if (start) begin
         ocupado <= 1'b1;
         passo   <= '0;
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
      end else if (ocupado) begin
         acc    <= produto_c;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         passo  <= passo + 4'd1;
         if (passo == 4'd15) ocupado <= 1'b0;
      end
   end

endmodule

// File: rtl/estagio_execucao.sv
// Execute/write-back stage behind a 16x16 register bank with registered reads.
// Ports: instr_valid/instrucao/pronto (intake handshake), entrada1/entrada2
// (bank read addresses, combinational), saida1/saida2 (bank read data, one
// cycle later), entrada3/dado/sinal (registered bank write port).
module estagio_execucao
   import pkg_processador::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instrucao,
   output logic              pronto,
   output logic [ADDR_W-1:0] entrada1,
   output logic [ADDR_W-1:0] entrada2,
   input  logic [DATA_W-1:0] saida1,
   input  logic [DATA_W-1:0] saida2,
   output logic [ADDR_W-1:0] entrada3,
   output logic [DATA_W-1:0] dado,
   output logic              sinal
);

   s1_t               s1;
   wb_t               ult;
   estado_t           estado;
   estado_t           estado_prox;
   logic              s1_mul;
   logic              mul_start_c;
   logic              mul_done;
   logic [DATA_W-1:0] mul_produto;
   logic [ADDR_W-1:0] mul_rd;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] resultado;
   logic              aceita;

   assign entrada1 = instrucao[RS_MSB:RS_LSB];
   assign entrada2 = instrucao[RT_MSB:RT_LSB];
   assign s1_mul   = s1.valid && (s1.opcode == OP_MUL);
   assign aceita   = instr_valid && pronto;

   // Operand forwarding: the newest in-flight write wins, then the one before
   // it (the bank read on that edge still returned the old value), then bank.
   always_comb begin
      op_a = saida1;
      if (sinal && (entrada3 == s1.rs))            op_a = dado;
      else if (ult.valid && (ult.addr == s1.rs))   op_a = ult.dado;
      op_b = saida2;
      if (sinal && (entrada3 == s1.rt))            op_b = dado;
      else if (ult.valid && (ult.addr == s1.rt))   op_b = ult.dado;
   end

   // Single-cycle ALU.
   always_comb begin
      resultado = '0;
      case (s1.opcode)
         OP_ADD:  resultado = op_a + op_b;
         OP_SUB:  resultado = op_a - op_b;
         OP_AND:  resultado = op_a & op_b;
         OP_OR:   resultado = op_a | op_b;
         OP_XOR:  resultado = op_a ^ op_b;
         OP_SLT:  resultado = DATA_W'($signed(op_a) < $signed(op_b));
         OP_SHL:  resultado = op_a << op_b[3:0];
         OP_SHR:  resultado = op_a >> op_b[3:0];
         OP_LI:   resultado = {8'h00, s1.imm};
         default: resultado = '0;
      endcase
   end

   // Stall FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= OCIOSO;
      else        estado <= estado_prox;
   end

   // Stall FSM next state.
   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:  if (s1_mul)   estado_prox = MULT;
         MULT:    if (mul_done) estado_prox = OCIOSO;
         default: estado_prox = OCIOSO;
      endcase
   end

   // Stall FSM outputs: intake blocks while a MUL waits in S1 or is running.
   always_comb begin
      pronto      = 1'b0;
      mul_start_c = 1'b0;
      if (estado == OCIOSO) begin
         pronto      = !s1_mul;
         mul_start_c = s1_mul;
      end
   end

   // S1: accepted instruction; emptied whenever nothing is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else if (aceita) begin
         s1.valid  <= 1'b1;
         s1.opcode <= instrucao[OPC_MSB:OPC_LSB];
         s1.rd     <= instrucao[RD_MSB:RD_LSB];
         s1.rs     <= instrucao[RS_MSB:RS_LSB];
         s1.rt     <= instrucao[RT_MSB:RT_LSB];
         s1.imm    <= instrucao[IMM_MSB:IMM_LSB];
      end else begin
         s1.valid <= 1'b0;
      end
   end

   // Destination of the running multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           mul_rd <= '0;
      else if (mul_start_c) mul_rd <= s1.rd;
   end

   // WB register (bank write port) and its one-cycle-delayed copy ULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinal    <= 1'b0;
         entrada3 <= '0;
         dado     <= '0;
         ult      <= '0;
      end else begin
         ult.valid <= sinal;
         ult.addr  <= entrada3;
         ult.dado  <= dado;
         if (s1.valid && escreve_direto(s1.opcode)) begin
            sinal    <= 1'b1;
            entrada3 <= s1.rd;
            dado     <= resultado;
         end else if (mul_done) begin
            sinal    <= 1'b1;
            entrada3 <= mul_rd;
            dado     <= mul_produto;
         end else begin
            sinal <= 1'b0;
         end
      end
   end

   multiplicador_serial u_mult (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (mul_start_c),
      .a         (op_a),
      .b         (op_b),
      .done_c    (mul_done),
      .produto_c (mul_produto)
   );

endmodule

// File: tb/tb_estagio_execucao.sv
// Bench for estagio_execucao: register bank with registered reads, and an
// architectural model that executes accepted instructions in program order.
module tb_estagio_execucao;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [15:0] instrucao;
   logic        pronto;
   logic [3:0]  entrada1, entrada2, entrada3;
   logic [15:0] saida1, saida2, dado;
   logic        sinal;

   always #5 clk = ~clk;

   estagio_execucao dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instrucao   (instrucao),
      .pronto      (pronto),
      .entrada1    (entrada1),
      .entrada2    (entrada2),
      .saida1      (saida1),
      .saida2      (saida2),
      .entrada3    (entrada3),
      .dado        (dado),
      .sinal       (sinal)
   );

   // Register bank: read data registered, read-during-write returns old value.
   logic [15:0] bank [16];
   logic        bank_init;
   always @(posedge clk) begin
      if (!bank_init) begin
         for (int i = 0; i < 16; i++) bank[i] <= '0;
         saida1 <= '0;
         saida2 <= '0;
      end else begin
         saida1 <= bank[entrada1];
         saida2 <= bank[entrada2];
         if (sinal) bank[entrada3] <= dado;
      end
   end

   typedef struct {
      logic [3:0]  rd;
      logic [15:0] val;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [15:0] arch [16];   // register values in program order
   logic [15:0] comm [16];   // register values already written to the bank
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_mul = -100;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [7:0] imm);
      int     ia, ib, sa, sb, sh;
      longint p;
      ia = int'(a);
      ib = int'(b);
      sa = (ia >= 32768) ? ia - 65536 : ia;
      sb = (ib >= 32768) ? ib - 65536 : ib;
      sh = ib % 16;
      p  = longint'(ia) * longint'(ib);
      case (op)
         4'h0: return 16'((ia + ib) % 65536);
         4'h1: return 16'((ia - ib + 65536) % 65536);
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return (sa < sb) ? 16'd1 : 16'd0;
         4'h6: return 16'((ia * (1 << sh)) % 65536);
         4'h7: return 16'(ia / (1 << sh));
         4'h8: return 16'(p % 65536);
         default: return {8'h00, imm};
      endcase
   endfunction

   function automatic logic model_pronto();
      return !((cyc - last_mul >= 1) && (cyc - last_mul <= 17));
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
      return {op, rd, rs, rt};
   endfunction

   function automatic logic [15:0] mk_li(input logic [3:0] rd, input logic [7:0] imm);
      return {4'h9, rd, imm};
   endfunction

   task automatic model_accept(input logic [15:0] ins);
      logic [3:0] op, rd, rs, rt;
      exp_t       e;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      if (op <= 4'h9) begin
         e.rd  = rd;
         e.val = ref_result(op, arch[rs], arch[rt], ins[7:0]);
         e.due = cyc + ((op == 4'h8) ? 18 : 2);
         q.push_back(e);
         arch[rd] = e.val;
         if (op == 4'h8) last_mul = cyc;
      end
   endtask

   // Checks the current cycle's outputs against the model.
   task automatic check_cycle();
      logic due_now;
      exp_t e;
      due_now = (q.size() > 0) && (q[0].due == cyc);
      chk("pronto", 16'(pronto), 16'(model_pronto()));
      chk("sinal", 16'(sinal), 16'(due_now));
      chk("entrada1", 16'(entrada1), 16'(instrucao[7:4]));
      chk("entrada2", 16'(entrada2), 16'(instrucao[3:0]));
      if (due_now) begin
         e = q.pop_front();
         if (sinal) begin
            chk("entrada3", 16'(entrada3), 16'(e.rd));
            chk("dado", dado, e.val);
         end
         comm[e.rd] = e.val;
      end
   endtask

   // One clock cycle: drive inputs, check outputs, advance past the edge.
   task automatic step(input logic v, input logic [15:0] ins, output logic acc);
      instr_valid = v;
      instrucao   = ins;
      #1;
      check_cycle();
      acc = v && model_pronto();
      if (acc) model_accept(ins);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input logic [15:0] ins);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 40) begin
         step(1'b1, ins, acc);
         n++;
      end
      chk("issue_accepted", 16'(acc), 16'd1);
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_sinal", 16'(sinal), 16'd0);
      chk("rst_dado", dado, 16'd0);
      chk("rst_entrada3", 16'(entrada3), 16'd0);
      chk("rst_pronto", 16'(pronto), 16'd1);
      q.delete();
      for (int i = 0; i < 16; i++) arch[i] = comm[i];
      last_mul = -100;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      logic acc;
      for (int n = 0; n < 40; n++) begin
         if (q.size() == 0) break;
         step(1'b0, 16'h0000, acc);
      end
      chk("drain_empty", 16'(q.size()), 16'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("bank_r%0d", i), bank[i], comm[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   t0, t_acc, n;
      logic [15:0] h;
      for (int i = 0; i < 16; i++) begin
         arch[i] = '0;
         comm[i] = '0;
      end
      instr_valid = 1'b0;
      instrucao   = 16'h0000;
      bank_init   = 1'b0;
      do_reset();
      bank_init = 1'b1;

      // LI/LI/ADD back to back: R1 via ULT, R2 via WB.
      issue(mk_li(4'd1, 8'd5));
      issue(mk_li(4'd2, 8'd7));
      issue(mk(4'h0, 4'd3, 4'd1, 4'd2));
      drain();
      chk("li_add_r3", bank[3], 16'd12);

      // SUB / SLT / SHL.
      issue(mk_li(4'd1, 8'd3));
      issue(mk_li(4'd9, 8'd1));
      issue(mk(4'h1, 4'd2, 4'd0, 4'd9));
      issue(mk(4'h1, 4'd4, 4'd1, 4'd2));
      issue(mk(4'h5, 4'd5, 4'd2, 4'd1));
      issue(mk(4'h6, 4'd6, 4'd1, 4'd1));
      drain();
      chk("r2_ffff", bank[2], 16'hFFFF);
      chk("sub_r4", bank[4], 16'h0004);
      chk("slt_r5", bank[5], 16'h0001);
      chk("shl_r6", bank[6], 16'h0018);

      // MUL stall with a dependent instruction held on instr_valid.
      issue(mk_li(4'd1, 8'd150));
      issue(mk_li(4'd2, 8'd150));
      issue(mk(4'h0, 4'd1, 4'd1, 4'd1));
      issue(mk(4'h0, 4'd2, 4'd2, 4'd2));
      drain();
      chk("r1_300", bank[1], 16'd300);
      step(1'b1, mk(4'h8, 4'd7, 4'd1, 4'd2), acc);
      chk("mul_accepted", 16'(acc), 16'd1);
      t0 = cyc - 1;
      h = mk(4'h0, 4'd8, 4'd7, 4'd7);
      acc = 1'b0;
      t_acc = -1;
      n = 0;
      while (!acc && n < 30) begin
         step(1'b1, h, acc);
         if (acc) t_acc = cyc - 1;
         n++;
      end
      chk("mul_hold_accept_delay", 16'(t_acc - t0), 16'd18);
      drain();
      chk("mul_r7", bank[7], 16'h5F90);
      chk("mul_dep_r8", bank[8], 16'hBF20);

      // Reset while the multiply is in flight: R7 must keep its old value.
      step(1'b1, mk(4'h8, 4'd7, 4'd1, 4'd9), acc);
      chk("mul2_accepted", 16'(acc), 16'd1);
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, acc);
      do_reset();
      drain();
      chk("mul_abort_r7", bank[7], 16'h5F90);
      issue(mk(4'h0, 4'd10, 4'd1, 4'd9));
      drain();
      chk("post_rst_add", bank[10], 16'd301);

      // NOP/undefined opcodes write nothing and do not disturb forwarding.
      for (int op = 10; op < 16; op++) issue(mk(4'(op), 4'd11, 4'd1, 4'd2));
      issue(mk_li(4'd13, 8'd4));
      issue(mk(4'hC, 4'd13, 4'd13, 4'd13));
      issue(mk(4'h0, 4'd14, 4'd13, 4'd13));
      drain();
      chk("nop_r11_untouched", bank[11], 16'd0);
      chk("fwd_over_nop", bank[14], 16'd8);

      // Randomized stream with dense register reuse and one mid-stream reset.
      for (int i = 0; i < 400; i++) begin
         logic        v;
         logic [3:0]  op;
         logic [15:0] ins;
         v  = ($urandom_range(0, 3) != 0);
         op = 4'($urandom_range(0, 15));
         ins = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
         if (op == 4'h9) ins[7:0] = 8'($urandom);
         if (i == 200) do_reset();
         else step(v, ins, acc);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
